// File: rtl/axi_bridge_pkg.sv
// Shared definitions for the CPU-to-AXI3 bridge: FSM encodings, transaction
// IDs, fixed AXI field values and the write-strobe helper.
package axi_bridge_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } rstate_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_B    = 2'd2
  } wstate_e;

  localparam logic [3:0] AXI_ID_INST = 4'd0;
  localparam logic [3:0] AXI_ID_DATA = 4'd1;

  // Every transfer is a single-beat INCR burst
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_LOCK_NONE  = 2'b00;
  localparam logic [3:0] AXI_CACHE_NONE = 4'b0000;
  localparam logic [2:0] AXI_PROT_NONE  = 3'b000;

  // Byte lanes touched by a store of the given size at the given byte offset;
  // wdata is not shifted, so the core must already place the bytes in-lane
  function automatic logic [3:0] wstrb_of(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's instruction and data SRAM-like ports onto one AXI3
// master. One read and one write may be in flight; data reads win over
// instruction reads and a data read to a word with a pending write waits.
module cpu_axi_bridge
  import axi_bridge_pkg::*;
#(
  parameter logic [3:0] ID_INST = AXI_ID_INST,
  parameter logic [3:0] ID_DATA = AXI_ID_DATA
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction port
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  // AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  rstate_e     r_state_q, r_state_d;
  wstate_e     w_state_q, w_state_d;

  logic [31:0] rd_addr_q, rd_addr_d;
  logic [1:0]  rd_size_q, rd_size_d;
  logic [3:0]  rd_id_q,   rd_id_d;

  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [1:0]  wr_size_q, wr_size_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q,  w_done_d;

  logic        r_idle, w_idle, no_raw;
  logic        data_rd_ok, data_wr_ok;
  logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic        r_conflict;

  // Response status and the ignored instruction-side write fields are not used
  logic        unused_ok;
  assign unused_ok = ^{inst_wr, inst_wdata, rresp, rlast, bid, bresp};

  assign r_idle = (r_state_q == R_IDLE);
  assign w_idle = (w_state_q == W_IDLE);

  // A read may not overtake a pending write to the same word
  assign no_raw = w_idle | (data_addr[31:2] != wr_addr_q[31:2]);

  assign data_rd_ok   = data_req & ~data_wr & r_idle & no_raw;
  assign data_wr_ok   = data_req &  data_wr & w_idle;
  assign data_addr_ok = data_rd_ok | data_wr_ok;
  assign inst_addr_ok = inst_req & r_idle & ~(data_req & ~data_wr);

  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid  & rready;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid  & wready;
  assign b_hs  = bvalid  & bready;

  // A data read beat and a B response would both map onto data_data_ok
  assign r_conflict = rvalid & (rid == ID_DATA) & (r_state_q == R_R);

  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;
  assign inst_data_ok = r_hs & (rid == ID_INST);
  assign data_data_ok = (r_hs & (rid == ID_DATA)) | b_hs;

  assign arid    = rd_id_q;
  assign araddr  = rd_addr_q;
  assign arsize  = {1'b0, rd_size_q};
  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK_NONE;
  assign arcache = AXI_CACHE_NONE;
  assign arprot  = AXI_PROT_NONE;

  assign awid    = ID_DATA;
  assign awaddr  = wr_addr_q;
  assign awsize  = {1'b0, wr_size_q};
  assign awlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = AXI_LOCK_NONE;
  assign awcache = AXI_CACHE_NONE;
  assign awprot  = AXI_PROT_NONE;

  assign wid     = ID_DATA;
  assign wdata   = wr_data_q;
  assign wstrb   = wstrb_of(wr_size_q, wr_addr_q[1:0]);
  assign wlast   = 1'b1;

  // Read FSM state and captured request registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      rd_addr_q <= '0;
      rd_size_q <= '0;
      rd_id_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      rd_addr_q <= rd_addr_d;
      rd_size_q <= rd_size_d;
      rd_id_q   <= rd_id_d;
    end
  end

  // Read FSM next state: capture the winning read, then AR, then R
  always_comb begin
    r_state_d = r_state_q;
    rd_addr_d = rd_addr_q;
    rd_size_d = rd_size_q;
    rd_id_d   = rd_id_q;
    case (r_state_q)
      R_IDLE: begin
        if (data_rd_ok) begin
          rd_addr_d = data_addr;
          rd_size_d = data_size;
          rd_id_d   = ID_DATA;
          r_state_d = R_AR;
        end else if (inst_addr_ok) begin
          rd_addr_d = inst_addr;
          rd_size_d = inst_size;
          rd_id_d   = ID_INST;
          r_state_d = R_AR;
        end
      end
      R_AR:    if (ar_hs) r_state_d = R_R;
      R_R:     if (r_hs)  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM outputs
  always_comb begin
    arvalid = (r_state_q == R_AR);
    rready  = (r_state_q == R_R);
  end

  // Write FSM state, captured request and per-channel handshake flags
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state_q <= W_IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_size_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_size_q <= wr_size_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Write FSM next state: AW and W complete independently, B follows both
  always_comb begin
    w_state_d = w_state_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_size_d = wr_size_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (w_state_q)
      W_IDLE: begin
        if (data_wr_ok) begin
          wr_addr_d = data_addr;
          wr_data_d = data_wdata;
          wr_size_d = data_size;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_AW;
        end
      end
      W_AW: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q  | w_hs;
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) w_state_d = W_B;
      end
      W_B:     if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM outputs; B is held off while a data read beat is being returned
  always_comb begin
    awvalid = (w_state_q == W_AW) & ~aw_done_q;
    wvalid  = (w_state_q == W_AW) & ~w_done_q;
    bready  = (w_state_q == W_B)  & ~r_conflict;
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: the bench plays the AXI slave, expected
// responses are queued per port and checked whenever a data_ok fires.
module tb_cpu_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  typedef struct {
    logic        is_wr;
    logic [31:0] data;
  } exp_t;

  exp_t        data_q[$];
  logic [31:0] inst_q[$];

  int vectors = 0;
  int miscompares = 0;

  cpu_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_data(input logic is_wr, input logic [31:0] d);
    exp_t e;
    e.is_wr = is_wr;
    e.data  = d;
    data_q.push_back(e);
  endtask

  // Scoreboard: every data_ok must match the oldest expected response
  always @(negedge clk) begin
    if (inst_data_ok) begin
      check("inst_resp_expected", inst_q.size(), (inst_q.size() == 0) ? 32'd1 : inst_q.size());
      if (inst_q.size() != 0) check("inst_rdata", inst_rdata, inst_q.pop_front());
    end
    if (data_data_ok) begin
      check("data_resp_expected", data_q.size(), (data_q.size() == 0) ? 32'd1 : data_q.size());
      if (data_q.size() != 0) begin
        exp_t e;
        e = data_q.pop_front();
        check("data_resp_kind", {31'd0, bvalid & bready}, {31'd0, e.is_wr});
        if (!e.is_wr) check("data_rdata", data_rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

    // ---- reset state
    step(); step(); step();
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_inst_addr_ok", inst_addr_ok, 0);
    check("rst_data_addr_ok", data_addr_ok, 0);
    check("rst_araddr", araddr, 0);
    check("rst_awaddr", awaddr, 0);
    resetn = 1'b1;
    step();

    // ---- instruction read with minimum latency
    inst_req = 1; inst_addr = 32'hBFC00000; inst_size = 2'd2; arready = 1;
    #1 check("t1_inst_addr_ok", inst_addr_ok, 1);
    step();
    inst_req = 0;
    #1;
    check("t1_arvalid", arvalid, 1);
    check("t1_araddr", araddr, 32'hBFC00000);
    check("t1_arid", arid, 0);
    check("t1_arsize", arsize, 3'd2);
    check("t1_arlen", arlen, 0);
    check("t1_arburst", arburst, 2'b01);
    check("t1_inst_data_ok_early", inst_data_ok, 0);
    step();
    rvalid = 1; rid = 4'd0; rdata = 32'h3C1D0001;
    inst_q.push_back(32'h3C1D0001);
    #1;
    check("t1_rready", rready, 1);
    check("t1_inst_data_ok", inst_data_ok, 1);
    check("t1_arvalid_low", arvalid, 0);
    step();
    rvalid = 0;
    #1 check("t1_rready_low", rready, 0);

    // ---- simultaneous data and instruction reads
    data_req = 1; data_wr = 0; data_addr = 32'h00000100; data_size = 2'd2;
    inst_req = 1; inst_addr = 32'h00000200;
    #1;
    check("t2_data_addr_ok", data_addr_ok, 1);
    check("t2_inst_addr_ok", inst_addr_ok, 0);
    step();
    data_req = 0;
    #1;
    check("t2_arid", arid, 1);
    check("t2_araddr", araddr, 32'h00000100);
    check("t2_inst_blocked_ar", inst_addr_ok, 0);
    step();
    rvalid = 1; rid = 4'd1; rdata = 32'h11112222;
    push_data(1'b0, 32'h11112222);
    #1;
    check("t2_data_data_ok", data_data_ok, 1);
    check("t2_inst_data_ok_low", inst_data_ok, 0);
    check("t2_inst_blocked_r", inst_addr_ok, 0);
    step();
    rvalid = 0;
    #1 check("t2_inst_accepted", inst_addr_ok, 1);
    step();
    inst_req = 0;
    #1;
    check("t2_inst_araddr", araddr, 32'h00000200);
    check("t2_inst_arid", arid, 0);
    step();
    rvalid = 1; rid = 4'd0; rdata = 32'h5555AAAA;
    inst_q.push_back(32'h5555AAAA);
    step();
    rvalid = 0;

    // ---- byte write, W delayed three cycles behind AW
    awready = 1; wready = 0;
    data_req = 1; data_wr = 1; data_size = 2'd0; data_addr = 32'h00000003;
    data_wdata = 32'h000000AB;
    #1 check("t3_data_addr_ok", data_addr_ok, 1);
    step();
    data_req = 0;
    #1;
    check("t3_awvalid", awvalid, 1);
    check("t3_wvalid", wvalid, 1);
    check("t3_awaddr", awaddr, 32'h00000003);
    check("t3_awsize", awsize, 3'd0);
    check("t3_wstrb", wstrb, 4'b1000);
    check("t3_wdata", wdata, 32'h000000AB);
    check("t3_wlast", wlast, 1);
    check("t3_awid", awid, 1);
    step();
    #1;
    check("t3_awvalid_dropped", awvalid, 0);
    check("t3_wvalid_held", wvalid, 1);
    step();
    #1;
    check("t3_wvalid_held2", wvalid, 1);
    check("t3_bready_not_yet", bready, 0);
    step();
    wready = 1;
    #1 check("t3_wvalid_held3", wvalid, 1);
    step();
    wready = 0;
    #1;
    check("t3_wvalid_done", wvalid, 0);
    check("t3_bready", bready, 1);
    check("t3_no_early_ok", data_data_ok, 0);
    step();
    bvalid = 1;
    push_data(1'b1, 32'h0);
    #1 check("t3_b_data_ok", data_data_ok, 1);
    step();
    bvalid = 0;
    #1 check("t3_bready_low", bready, 0);

    // ---- read-after-write guard
    awready = 1; wready = 1;
    data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h00001000;
    data_wdata = 32'hDEADBEEF;
    #1 check("t4_wr_addr_ok", data_addr_ok, 1);
    step();
    data_req = 0;
    #1 check("t4_wstrb_word", wstrb, 4'b1111);
    step();
    data_req = 1; data_wr = 0; data_addr = 32'h00001000;
    #1 check("t4_raw_stall", data_addr_ok, 0);
    step();
    #1 check("t4_raw_stall2", data_addr_ok, 0);
    data_addr = 32'h00001004;
    #1 check("t4_other_word_ok", data_addr_ok, 1);
    step();
    data_req = 0;
    #1 check("t4_araddr_1004", araddr, 32'h00001004);
    step();
    rvalid = 1; rid = 4'd1; rdata = 32'h77778888;
    push_data(1'b0, 32'h77778888);
    #1 check("t4_rd_data_ok", data_data_ok, 1);
    step();
    rvalid = 0;
    data_req = 1; data_addr = 32'h00001000;
    bvalid = 1;
    push_data(1'b1, 32'h0);
    #1;
    check("t4_raw_stall_b", data_addr_ok, 0);
    check("t4_b_data_ok", data_data_ok, 1);
    step();
    bvalid = 0;
    #1 check("t4_raw_released", data_addr_ok, 1);
    step();
    data_req = 0;
    #1 check("t4_araddr_1000", araddr, 32'h00001000);
    step();
    rvalid = 1; rid = 4'd1; rdata = 32'h99990000;
    push_data(1'b0, 32'h99990000);
    step();
    rvalid = 0;

    // ---- R and B land in the same cycle on the data port
    data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h00002000;
    data_wdata = 32'h12345678;
    #1 check("t5_wr_addr_ok", data_addr_ok, 1);
    step();
    data_wr = 0; data_addr = 32'h00003000;
    #1 check("t5_rd_addr_ok", data_addr_ok, 1);
    step();
    data_req = 0;
    #1;
    check("t5_arvalid", arvalid, 1);
    check("t5_bready_idle", bready, 1);
    step();
    rvalid = 1; rid = 4'd1; rdata = 32'hCAFE0001; bvalid = 1;
    push_data(1'b0, 32'hCAFE0001);
    push_data(1'b1, 32'h0);
    #1;
    check("t5_bready_blocked", bready, 0);
    check("t5_rd_data_ok", data_data_ok, 1);
    step();
    rvalid = 0;
    #1;
    check("t5_bready_after", bready, 1);
    check("t5_wr_data_ok", data_data_ok, 1);
    step();
    bvalid = 0;
    #1 check("t5_bready_low", bready, 0);

    // ---- reset while a read is waiting for R
    inst_req = 1; inst_addr = 32'h00000300;
    #1 check("t6_inst_addr_ok", inst_addr_ok, 1);
    step();
    inst_req = 0;
    #1 check("t6_arvalid", arvalid, 1);
    step();
    #1 check("t6_rready", rready, 1);
    resetn = 0;
    step();
    resetn = 1;
    rvalid = 1; rid = 4'd0; rdata = 32'h0BAD0BAD;
    #1;
    check("t6_arvalid_rst", arvalid, 0);
    check("t6_rready_rst", rready, 0);
    check("t6_no_data_ok", inst_data_ok, 0);
    check("t6_araddr_cleared", araddr, 0);
    step();
    rvalid = 0;
    inst_req = 1; inst_addr = 32'h00000400;
    #1 check("t6_new_accept", inst_addr_ok, 1);
    step();
    inst_req = 0;
    #1 check("t6_new_araddr", araddr, 32'h00000400);
    step();
    rvalid = 1; rid = 4'd0; rdata = 32'h0400ABCD;
    inst_q.push_back(32'h0400ABCD);
    step();
    rvalid = 0;
    step(); step();

    check("end_inst_q_drained", inst_q.size(), 0);
    check("end_data_q_drained", data_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
- Converts the core's two SRAM-like ports (instruction, data) into a single AXI3 master port.
- Sits directly downstream of the CPU top, between the core and the AXI crossbar/RAM.
- Supports one outstanding read and one outstanding write at a time.
- Arbitrates between the two ports and returns each response to its requester.

Parameters:
- ID_INST, 4'd0, arid used for instruction reads.
- ID_DATA, 4'd1, arid/awid used for data accesses.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- inst_req  in  1  instruction request
- inst_wr  in  1  ignored; instruction side is read-only
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  32  byte address
- inst_wdata  in  32  unused
- inst_rdata  out  32  read data, valid with inst_data_ok
- inst_addr_ok  out  1  request accepted this cycle
- inst_data_ok  out  1  response returned this cycle
- data_req / data_wr / data_size / data_addr / data_wdata  in  1/1/2/32/32  data request fields
- data_rdata  out  32  read data
- data_addr_ok  out  1  request accepted this cycle
- data_data_ok  out  1  response returned this cycle
- arid / araddr / arsize / arvalid  out  4/32/3/1  AR channel
- arlen / arburst / arlock / arcache / arprot  out  8/2/2/4/3  tied 0 / 2'b01 / 0 / 0 / 0
- arready  in  1  AR handshake
- rid / rdata / rresp / rlast / rvalid  in  4/32/2/1/1  R channel
- rready  out  1  R handshake
- awid / awaddr / awsize / awvalid  out  4/32/3/1  AW channel
- awlen / awburst / awlock / awcache / awprot  out  8/2/2/4/3  tied as on AR
- awready  in  1  AW handshake
- wid / wdata / wstrb / wlast / wvalid  out  4/32/4/1/1  W channel; wlast tied 1
- wready  in  1  W handshake
- bid / bresp / bvalid  in  4/2/1  B channel
- bready  out  1  B handshake

Behaviour:
- Reset (resetn=0 at posedge): both FSMs go to IDLE.
  - All valid/ready outputs and addr_ok/data_ok outputs read 0.
  - Stored address, size, data and id registers are cleared to 0.
  - Any in-flight transaction is abandoned; no response is delivered.
- Read FSM: R_IDLE -> R_AR -> R_R -> R_IDLE.
  - R_AR: arvalid=1; leave when arvalid&arready.
  - R_R: rready=1; leave when rvalid&rready.
- Write FSM: W_IDLE -> W_AW -> W_B -> W_IDLE.
  - W_AW: awvalid and wvalid are raised together; each drops independently after its own handshake.
  - Move to W_B when both handshakes are done, whether they occur in the same cycle or in either order.
  - W_B: bready=1 (subject to the conflict rule below); leave on bvalid&bready.
- Acceptance (combinational, same cycle as req):
  - data_addr_ok = data_req & (data_wr ? W_IDLE : (R_IDLE & no_raw)).
  - inst_addr_ok = inst_req & R_IDLE & ~(data_req & ~data_wr).
  - Data reads have priority over instruction reads.
  - Requests are captured into the FSM registers on the addr_ok cycle; AR/AW become valid the next cycle.
- RAW guard: no_raw = W_IDLE | (data_addr[31:2] != stored awaddr[31:2]). A data read to a word with a pending write stalls until the B response completes.
- Size and strobe:
  - arsize/awsize = {1'b0, size}.
  - wstrb: size 0 -> 4'b0001<<addr[1:0]; size 1 -> 4'b0011<<addr[1:0]; size 2 -> 4'b1111.
  - wdata is passed unshifted.
- Response routing:
  - inst_data_ok = rvalid & rready & rid==ID_INST.
  - data_data_ok = (rvalid & rready & rid==ID_DATA) | (bvalid & bready).
  - inst_rdata and data_rdata are driven combinationally from rdata.
- Conflict rule: bready is forced to 0 in any cycle where rvalid & rid==ID_DATA & R_R, so the data port never sees two responses in one cycle.
- Minimum read latency: addr_ok at T, arvalid at T+1; with arready=1 and a one-cycle slave, data_ok arrives at T+2.
- A read and a write may be outstanding simultaneously. Instruction and data reads never overlap.

Decomposition:
- Shared package (axi_bridge_pkg):
  - R/W state encodings.
  - ID_INST/ID_DATA constants.
  - AXI fixed-field constants (burst INCR, len 0).
  - wstrb-from-size/offset function.
- No sub-module; both FSMs live in one file.

Test Plan:
- inst read 0xBFC00000, arready=1, rvalid next cycle with rdata=0x3C1D0001 -> araddr=0xBFC00000, arid=0, inst_data_ok 2 cycles after addr_ok, inst_rdata=0x3C1D0001.
- data and inst read requests in the same cycle -> data_addr_ok=1, inst_addr_ok=0; after the data R completes, inst is accepted next.
- data byte write addr 0x...03 with wdata 0x000000AB -> wstrb=4'b1000, awsize=0. Then hold wready=0 for 3 cycles while awready=1 -> stays in W_AW until W completes, single data_data_ok on bvalid.
- data write to 0x1000 pending (bvalid held low), then data read 0x1000 -> data_addr_ok=0 until the B handshake; a read to 0x1004 is accepted immediately.
- pending data read and data write, rvalid(rid=1) and bvalid in the same cycle -> bready=0 that cycle, read data_ok first, write data_ok next cycle.
- resetn=0 mid R_R -> next cycle arvalid=rready=0, no data_ok, and a new request is accepted after release.
